mem_write_monitor: RTL and testbench

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

---
 rtl/mem_write_monitor.sv | 188 ++++++++++++++++++
 tb/tb_mem_write_monitor.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_monitor.sv
// mem_write_monitor: checks processor stores against a small table of expected
// {address, data} writes, either in index order or in any order, with optional timeout.
module mem_write_monitor #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TO_W    = 16,
  parameter int ORDERED = 1,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_adr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [CW-1:0]    cfg_count,
  input  logic [TO_W-1:0]  timeout_lim,
  input  logic             start,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] DataAdr,
  input  logic [WIDTH-1:0] WriteData,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             done,
  output logic [CW-1:0]    match_cnt,
  output logic [1:0]       fail_code
);

  typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] adr_q  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] matched_q;
  logic [CW-1:0]    match_cnt_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    cnt_clamped;
  logic [TO_W-1:0]  lim_q;
  logic [TO_W-1:0]  cyc_q;
  logic [1:0]       fail_code_q, code_d;

  logic             cur_adr_hit, cur_data_hit, later_hit;
  logic             free_hit, free_adr_hit;
  logic [IW-1:0]    free_idx;
  logic             hit_match, hit_fail_data, hit_fail_order;
  logic [IW-1:0]    hit_idx;
  logic             completing, timed_out;

  assign cnt_clamped = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
  assign completing  = hit_match && ((match_cnt_q + CW'(1)) == count_q);
  assign timed_out   = (lim_q != '0) && (cyc_q == (lim_q - TO_W'(1)));

  // The table is only rewritable while idle, so it never changes under an armed check.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cfg_we) begin
      adr_q[cfg_idx]  <= cfg_adr;
      data_q[cfg_idx] <= cfg_data;
    end
  end

  // Scan downward so the lowest qualifying unmatched index wins free_idx.
  always_comb begin
    cur_adr_hit  = 1'b0;
    cur_data_hit = 1'b0;
    later_hit    = 1'b0;
    free_hit     = 1'b0;
    free_adr_hit = 1'b0;
    free_idx     = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if ((CW'(j) < count_q) && (adr_q[j] == DataAdr)) begin
        if (CW'(j) == match_cnt_q) begin
          cur_adr_hit  = 1'b1;
          cur_data_hit = (data_q[j] == WriteData);
        end
        if (CW'(j) > match_cnt_q) begin
          later_hit = 1'b1;
        end
        if (!matched_q[j]) begin
          free_adr_hit = 1'b1;
          if (data_q[j] == WriteData) begin
            free_hit = 1'b1;
            free_idx = IW'(j);
          end
        end
      end
    end
  end

  always_comb begin
    hit_match      = 1'b0;
    hit_fail_data  = 1'b0;
    hit_fail_order = 1'b0;
    hit_idx        = '0;
    if (MemWrite) begin
      if (ORDERED != 0) begin
        hit_match      = cur_adr_hit && cur_data_hit;
        hit_fail_data  = cur_adr_hit && !cur_data_hit;
        hit_fail_order = !cur_adr_hit && later_hit;
        hit_idx        = match_cnt_q[IW-1:0];
      end else begin
        hit_match     = free_hit;
        hit_fail_data = !free_hit && free_adr_hit;
        hit_idx       = free_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A completing match beats any failure raised in the same cycle.
  always_comb begin
    state_d = state_q;
    code_d  = fail_code_q;
    unique case (state_q)
      ARMED: begin
        if (completing) begin
          state_d = PASS;
        end else if (hit_fail_data) begin
          state_d = FAIL;
          code_d  = 2'b10;
        end else if (hit_fail_order) begin
          state_d = FAIL;
          code_d  = 2'b11;
        end else if (timed_out) begin
          state_d = FAIL;
          code_d  = 2'b01;
        end
      end
      default: begin
        if (start) begin
          state_d = (cnt_clamped == '0) ? PASS : ARMED;
          code_d  = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      match_cnt_q <= '0;
      matched_q   <= '0;
      cyc_q       <= '0;
      fail_code_q <= 2'b00;
      count_q     <= '0;
      lim_q       <= '0;
    end else begin
      fail_code_q <= code_d;
      if (state_q != ARMED) begin
        if (start) begin
          match_cnt_q <= '0;
          matched_q   <= '0;
          cyc_q       <= '0;
          count_q     <= cnt_clamped;
          lim_q       <= timeout_lim;
        end
      end else begin
        if (cyc_q != '1) begin
          cyc_q <= cyc_q + TO_W'(1);
        end
        if (hit_match) begin
          match_cnt_q        <= match_cnt_q + CW'(1);
          matched_q[hit_idx] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = (state_q == ARMED);
    pass = (state_q == PASS);
    fail = (state_q == FAIL);
    done = (state_q == PASS) || (state_q == FAIL);
  end

  assign match_cnt = match_cnt_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor: drives an in-order and an any-order monitor with the same
// stimulus and compares both against a queue-free behavioural model every cycle.
module tb_mem_write_monitor;

  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [31:0] cfg_adr;
  logic [31:0] cfg_data;
  logic [2:0]  cfg_count;
  logic [15:0] timeout_lim;
  logic        start;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;

  logic        busy [2];
  logic        pass [2];
  logic        fail [2];
  logic        done [2];
  logic [2:0]  match_cnt [2];
  logic [1:0]  fail_code [2];

  mem_write_monitor #(.WIDTH(32), .DEPTH(DEP), .TO_W(16), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .timeout_lim(timeout_lim), .start(start),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy[0]), .pass(pass[0]), .fail(fail[0]), .done(done[0]),
    .match_cnt(match_cnt[0]), .fail_code(fail_code[0])
  );

  mem_write_monitor #(.WIDTH(32), .DEPTH(DEP), .TO_W(16), .ORDERED(0)) u_any (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .timeout_lim(timeout_lim), .start(start),
    .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy[1]), .pass(pass[1]), .fail(fail[1]), .done(done[1]),
    .match_cnt(match_cnt[1]), .fail_code(fail_code[1])
  );

  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  // Model: mode 0 idle, 1 armed, 2 pass, 3 fail; index 0 in-order, 1 any-order.
  int          mMode [2];
  int          mCnt  [2];
  int          mCode [2];
  int          mN    [2];
  int          mLim  [2];
  int          mAge  [2];
  bit          mUsed [2][DEP];
  logic [31:0] mAdr  [2][DEP];
  logic [31:0] mDat  [2][DEP];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelStep(int m);
    bit hit;
    bit bad;
    bit timed;
    int code;
    if (mMode[m] == 0 && cfg_we) begin
      mAdr[m][cfg_idx] = cfg_adr;
      mDat[m][cfg_idx] = cfg_data;
    end
    if (!reset) begin
      mMode[m] = 0; mCnt[m] = 0; mCode[m] = 0; mAge[m] = 0;
      for (int k = 0; k < DEP; k++) mUsed[m][k] = 1'b0;
      return;
    end
    if (mMode[m] != 1) begin
      if (start) begin
        mN[m]   = (int'(cfg_count) > DEP) ? DEP : int'(cfg_count);
        mLim[m] = int'(timeout_lim);
        mCnt[m] = 0; mCode[m] = 0; mAge[m] = 0;
        for (int k = 0; k < DEP; k++) mUsed[m][k] = 1'b0;
        mMode[m] = (mN[m] == 0) ? 2 : 1;
      end
      return;
    end
    hit = 1'b0; bad = 1'b0; code = 0;
    if (MemWrite) begin
      if (m == 0) begin
        if (mAdr[0][mCnt[0]] == DataAdr) begin
          if (mDat[0][mCnt[0]] == WriteData) hit = 1'b1;
          else begin bad = 1'b1; code = 2; end
        end else begin
          for (int k = mCnt[0] + 1; k < mN[0]; k++)
            if (mAdr[0][k] == DataAdr) begin bad = 1'b1; code = 3; end
        end
      end else begin
        for (int k = 0; k < mN[1]; k++)
          if (!hit && !mUsed[1][k] && mAdr[1][k] == DataAdr && mDat[1][k] == WriteData) begin
            hit = 1'b1;
            mUsed[1][k] = 1'b1;
          end
        if (!hit)
          for (int k = 0; k < mN[1]; k++)
            if (!mUsed[1][k] && mAdr[1][k] == DataAdr) begin bad = 1'b1; code = 2; end
      end
    end
    timed = (mLim[m] != 0) && (mAge[m] + 1 == mLim[m]);
    mAge[m]++;
    if (hit) mCnt[m]++;
    if (hit && mCnt[m] == mN[m]) mMode[m] = 2;
    else if (bad) begin mMode[m] = 3; mCode[m] = code; end
    else if (timed) begin mMode[m] = 3; mCode[m] = 1; end
  endfunction

  // One clock with the currently driven inputs, then compare both DUTs to the model.
  task automatic applyStimulus();
    modelStep(0);
    modelStep(1);
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      checkOutput(m == 0 ? "ord.flags" : "any.flags",
                  {28'b0, busy[m], pass[m], fail[m], done[m]},
                  {28'b0, mMode[m] == 1, mMode[m] == 2, mMode[m] == 3, mMode[m] >= 2});
      checkOutput(m == 0 ? "ord.cnt_code" : "any.cnt_code",
                  {27'b0, match_cnt[m], fail_code[m]},
                  {27'b0, 3'(mCnt[m]), 2'(mCode[m])});
    end
  endtask

  // Direct check of one DUT against constants taken from the scenario itself.
  task automatic checkState(input int m, input string tag, input logic [3:0] flags,
                            input logic [2:0] cnt, input logic [1:0] code);
    checkOutput(tag, {25'b0, busy[m], pass[m], fail[m], done[m], match_cnt[m], fail_code[m]},
                {25'b0, flags, cnt, code});
  endtask

  task automatic idleInputs();
    reset = 1'b1; cfg_we = 1'b0; start = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
  endtask

  task automatic prog(input int idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_adr = a; cfg_data = d;
    applyStimulus();
    cfg_we = 1'b0;
  endtask

  task automatic arm(input int cnt, input int lim);
    start = 1'b1; cfg_count = 3'(cnt); timeout_lim = 16'(lim);
    applyStimulus();
    start = 1'b0;
  endtask

  task automatic storeW(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    applyStimulus();
    MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus();
  endtask

  function automatic logic [31:0] rAdr();
    if ($urandom_range(0, 7) == 0) return 32'h8000_0100;
    return 32'h100 + 32'(4 * $urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rDat();
    if ($urandom_range(0, 7) == 0) return 32'h8000_0001;
    return 32'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_adr = '0; cfg_data = '0;
    cfg_count = '0; timeout_lim = '0; start = 1'b0; MemWrite = 1'b0;
    DataAdr = '0; WriteData = '0;
    for (int m = 0; m < 2; m++) begin
      mMode[m] = 0; mCnt[m] = 0; mCode[m] = 0; mN[m] = 0; mLim[m] = 0; mAge[m] = 0;
      for (int k = 0; k < DEP; k++) begin
        mUsed[m][k] = 1'b0; mAdr[m][k] = '0; mDat[m][k] = '0;
      end
    end

    applyStimulus();
    applyStimulus();
    checkState(0, "reset.ord", 4'b0000, 3'd0, 2'b00);
    checkState(1, "reset.any", 4'b0000, 3'd0, 2'b00);
    idleInputs();

    // In-order single entry, an unrelated store is ignored.
    prog(0, 32'd100, 32'd25);
    arm(1, 0);
    storeW(32'd96, 32'd7);
    checkState(0, "ignore.ord", 4'b1000, 3'd0, 2'b00);
    storeW(32'd100, 32'd25);
    checkState(0, "single.ord", 4'b0101, 3'd1, 2'b00);

    // Out-of-order store: order violation vs accepted.
    doReset();
    prog(0, 32'd80, 32'hFFFF_FFFB);
    prog(1, 32'd100, 32'h0000_000E);
    arm(2, 0);
    storeW(32'd100, 32'h0000_000E);
    checkState(0, "order.ord", 4'b0011, 3'd0, 2'b11);
    checkState(1, "order.any1", 4'b1000, 3'd1, 2'b00);
    storeW(32'd80, 32'hFFFF_FFFB);
    checkState(1, "order.any2", 4'b0101, 3'd2, 2'b00);
    checkState(0, "sticky.ord", 4'b0011, 3'd0, 2'b11);

    // Data mismatch, then re-arm from FAIL.
    doReset();
    prog(0, 32'd100, 32'd25);
    arm(1, 0);
    storeW(32'd100, 32'd24);
    checkState(0, "data.ord", 4'b0011, 3'd0, 2'b10);
    checkState(1, "data.any", 4'b0011, 3'd0, 2'b10);
    arm(1, 0);
    storeW(32'd100, 32'd25);
    checkState(0, "rearm.ord", 4'b0101, 3'd1, 2'b00);

    // Timeout at the 10th armed cycle, and completion in that same cycle.
    doReset();
    prog(0, 32'd100, 32'd25);
    arm(1, 10);
    idle(9);
    checkState(0, "to9.ord", 4'b1000, 3'd0, 2'b00);
    idle(1);
    checkState(0, "to10.ord", 4'b0011, 3'd0, 2'b01);
    arm(1, 10);
    idle(9);
    storeW(32'd100, 32'd25);
    checkState(0, "tojoin.ord", 4'b0101, 3'd1, 2'b00);
    checkState(1, "tojoin.any", 4'b0101, 3'd1, 2'b00);

    // Reset mid-ARMED, then zero-count start.
    doReset();
    prog(0, 32'd100, 32'd25);
    prog(1, 32'd200, 32'd3);
    arm(2, 0);
    storeW(32'd100, 32'd25);
    checkState(0, "mid.ord", 4'b1000, 3'd1, 2'b00);
    doReset();
    checkState(0, "abort.ord", 4'b0000, 3'd0, 2'b00);
    arm(0, 0);
    checkState(0, "zero.ord", 4'b0101, 3'd0, 2'b00);

    // Count clamp, writes and start ignored while armed.
    doReset();
    for (int i = 0; i < DEP; i++) prog(i, 32'h200 + 32'(i), 32'hA5A5_0000 + 32'(i));
    arm(7, 0);
    storeW(32'h200, 32'hA5A5_0000);
    prog(1, 32'h200 + 32'd1, 32'h1234_5678);
    arm(1, 0);
    for (int i = 1; i < DEP; i++) storeW(32'h200 + 32'(i), 32'hA5A5_0000 + 32'(i));
    checkState(0, "clamp.ord", 4'b0101, 3'd4, 2'b00);
    checkState(1, "clamp.any", 4'b0101, 3'd4, 2'b00);

    // Randomized scenarios.
    for (int s = 0; s < 300; s++) begin
      idleInputs();
      if ($urandom_range(0, 1) == 1) doReset();
      for (int i = 0; i < DEP; i++) prog(i, rAdr(), rDat());
      arm(int'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25)));
      for (int c = 0; c < 30; c++) begin
        int k;
        k = int'($urandom_range(0, DEP - 1));
        MemWrite  = ($urandom_range(0, 9) < 7);
        DataAdr   = ($urandom_range(0, 3) == 0) ? rAdr() : mAdr[0][k];
        WriteData = ($urandom_range(0, 3) == 0) ? rDat() : mDat[0][k];
        cfg_we    = ($urandom_range(0, 19) == 0);
        cfg_idx   = 2'($urandom_range(0, 3));
        cfg_adr   = rAdr();
        cfg_data  = rDat();
        start     = ($urandom_range(0, 24) == 0);
        cfg_count = 3'($urandom_range(0, 7));
        timeout_lim = 16'($urandom_range(0, 20));
        reset     = ($urandom_range(0, 49) != 0);
        applyStimulus();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
